grid_ifft_feeder: RTL and testbench
===================================

Name: grid_ifft_feeder

Overview:
- Sits directly downstream of the PUSCH resource element mapper.
- Reads one completed 1200-subcarrier OFDM symbol from the double-banked grid memory the mapper writes.
- Reorders the subcarriers into natural 2048-point IFFT bin order, zero-fills the guard bins, and streams the result to the IFFT with valid/ready backpressure.
- Signals the mapper each time a grid bank is free for reuse.

Parameters:
- DATA_W, 18, sample width (I and Q each), signed; matches mapper FFT_Len.
- NFFT_LOG2, 11, log2 of IFFT size (2048 bins).
- N_SC, 1200, occupied subcarriers per symbol; must be even and less than 2^NFFT_LOG2.
- ADDR_W, 11, grid memory address width.

Ports:
- CLK_GF  in  1  clock.
- RST_GF  in  1  asynchronous, active-high reset.
- Sym_Ready  in  1  one-cycle pulse; the mapper has finished writing the current write bank (mapper Sym_Done).
- Grid_rd_en  out  1  grid memory read strobe.
- Grid_rd_bank  out  1  bank being read.
- Grid_rd_addr  out  ADDR_W  subcarrier index 0..N_SC-1.
- Grid_rd_I  in  DATA_W  read data, valid exactly 1 cycle after Grid_rd_en.
- Grid_rd_Q  in  DATA_W  read data, valid exactly 1 cycle after Grid_rd_en.
- IFFT_I  out  DATA_W  output sample, real part.
- IFFT_Q  out  DATA_W  output sample, imaginary part.
- IFFT_Valid  out  1  output sample valid.
- IFFT_Ready  in  1  IFFT accepts a sample.
- IFFT_Last  out  1  marks bin 2^NFFT_LOG2-1.
- Bin_idx  out  NFFT_LOG2  bin index of the current output sample.
- Buf_Free  out  1  one-cycle pulse; the bank just read may be overwritten.
- Busy  out  1  high in STREAM or DRAIN.
- Overflow  out  1  sticky request-overflow flag.

Behaviour:
- Reset (asynchronous, active-high): every output is 0, Grid_rd_bank is 0, the pending count is 0, and the state is IDLE. Assertion mid-symbol aborts the symbol immediately; no Buf_Free is issued.
- Handshake:
  - A sample transfers on a cycle with IFFT_Valid & IFFT_Ready.
  - While IFFT_Valid=1 and IFFT_Ready=0, IFFT_I, IFFT_Q, Bin_idx and IFFT_Last hold stable.
  - IFFT_Valid never drops without a transfer.
- Pending request counter (0..2):
  - Increments on Sym_Ready and decrements when a symbol starts.
  - Simultaneous increment and decrement leaves it unchanged.
  - Sym_Ready while the counter is 2 sets Overflow and is otherwise ignored. Overflow clears only on reset.
- Bin mapping, with H = N_SC/2 and N = 2^NFFT_LOG2:
  - Bins 0..H-1 read addr = bin + H.
  - Bins N-H..N-1 read addr = bin - (N-H).
  - Bins H..N-H-1 output 0+j0 with no memory read.
  - Default values: bins 0..599 carry subcarriers 600..1199; bins 600..1447 are zero; bins 1448..2047 carry subcarriers 0..599.
- Pipeline: issue stage (bin counter plus read) feeds a capture stage, which feeds a 2-entry output skid buffer.
  - A read or zero bin is issued only when the entries in flight plus the occupied skid entries total at most 1.
  - With IFFT_Ready held at 1 the block sustains 1 sample per cycle.
- State machine:
  - IDLE to STREAM when pending > 0 or Sym_Ready is asserted. The bin counter resets to 0.
  - STREAM issues bins 0..N-1. After bin N-1 is issued it moves to DRAIN.
  - DRAIN waits for the IFFT_Last transfer. On that transfer:
    - Buf_Free pulses on the next cycle.
    - Grid_rd_bank toggles.
    - If pending > 0, the block re-enters STREAM directly; otherwise it returns to IDLE.
- Latency: if Sym_Ready is sampled in IDLE at edge E0, the first Grid_rd_en is high in the cycle after E0 and IFFT_Valid with bin 0 is high after edge E0+2.
- Back-to-back symbols: the next symbol's bin 0 is valid no later than 3 cycles after the IFFT_Last transfer.
- Sym_Ready coinciding with the IFFT_Last transfer counts as pending and is served next.
- IFFT_Last is high only with Bin_idx = N-1.
- Busy is high from leaving IDLE until return to IDLE.

Test Plan:
1. Grid bank 0 holds I = addr, Q = -addr; pulse Sym_Ready with Ready=1 -> 2048 transfers:
   - bin0 = (600, -600), bin599 = (1199, -1199), bins 600..1447 = 0, bin1448 = (0, 0), bin2047 = (599, -599).
   - IFFT_Last only on bin2047; first valid 2 cycles after Sym_Ready; one Buf_Free; bank then 1.
2. Same stimulus with IFFT_Ready as a pseudo-random 50% pattern -> an identical sample sequence with no drops or duplicates; outputs stable while stalled.
3. Two Sym_Ready pulses 10 cycles apart -> 4096 transfers; the second symbol reads bank 1 and its bin 0 is valid ≤3 cycles after the first IFFT_Last transfer; two Buf_Free pulses; bank returns to 0.
4. Three Sym_Ready pulses during symbol 0 -> Overflow=1 after the third; exactly 3 symbols output in total (the one in progress plus 2 pending); Overflow remains 1.
5. Assert RST_GF at bin 1000 -> all outputs 0 immediately; no Buf_Free; bank 0; a following Sym_Ready restarts at bin 0 from bank 0.
6. Sym_Ready in the same cycle as the IFFT_Last transfer -> served as the next symbol; the pending count never drops below 0.

Source files
------------

// File: rtl/grid_ifft_feeder_if.sv
// Grid-memory read port, IFFT sample stream and mapper status lines of the
// IFFT feeder. The feeder uses the master modport; its neighbours use slave.
interface grid_ifft_feeder_if #(
  parameter int DATA_W    = 18,
  parameter int NFFT_LOG2 = 11,
  parameter int ADDR_W    = 11
);
  logic                        Sym_Ready;
  logic                        Grid_rd_en;
  logic                        Grid_rd_bank;
  logic [ADDR_W-1:0]           Grid_rd_addr;
  logic signed [DATA_W-1:0]    Grid_rd_I;
  logic signed [DATA_W-1:0]    Grid_rd_Q;
  logic signed [DATA_W-1:0]    IFFT_I;
  logic signed [DATA_W-1:0]    IFFT_Q;
  logic                        IFFT_Valid;
  logic                        IFFT_Ready;
  logic                        IFFT_Last;
  logic [NFFT_LOG2-1:0]        Bin_idx;
  logic                        Buf_Free;
  logic                        Busy;
  logic                        Overflow;

  modport master (
    input  Sym_Ready, Grid_rd_I, Grid_rd_Q, IFFT_Ready,
    output Grid_rd_en, Grid_rd_bank, Grid_rd_addr,
           IFFT_I, IFFT_Q, IFFT_Valid, IFFT_Last, Bin_idx,
           Buf_Free, Busy, Overflow
  );

  modport slave (
    output Sym_Ready, Grid_rd_I, Grid_rd_Q, IFFT_Ready,
    input  Grid_rd_en, Grid_rd_bank, Grid_rd_addr,
           IFFT_I, IFFT_Q, IFFT_Valid, IFFT_Last, Bin_idx,
           Buf_Free, Busy, Overflow
  );
endinterface

// File: rtl/grid_ifft_feeder.sv
// Reads one OFDM symbol of N_SC subcarriers from the double-banked grid,
// reorders it into natural IFFT bin order with zeroed guard bins and streams
// it to the IFFT under valid/ready backpressure.
// Pipeline: issue (bin counter + read strobe) -> capture (read data returns)
// -> 2-entry skid buffer whose head drives the IFFT outputs.
module grid_ifft_feeder #(
  parameter int DATA_W    = 18,
  parameter int NFFT_LOG2 = 11,
  parameter int N_SC      = 1200,
  parameter int ADDR_W    = 11
) (
  input  logic               CLK_GF,
  input  logic               RST_GF,
  grid_ifft_feeder_if.master bus
);
  localparam int N = 1 << NFFT_LOG2;
  localparam int H = N_SC / 2;
  localparam logic [NFFT_LOG2-1:0] C_LAST_BIN = NFFT_LOG2'(N - 1);
  localparam logic [NFFT_LOG2-1:0] C_H        = NFFT_LOG2'(H);
  localparam logic [NFFT_LOG2-1:0] C_HI_START = NFFT_LOG2'(N - H);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] i;
    logic signed [DATA_W-1:0] q;
    logic [NFFT_LOG2-1:0]     bin;
    logic                     last;
  } sample_t;

  state_t               r_state, w_state_nxt;
  logic [NFFT_LOG2-1:0] r_bin;
  logic [1:0]           r_pend;
  logic                 r_ovf, r_bank, r_free;
  logic                 r_cap_vld, r_cap_zero, r_cap_last;
  logic [NFFT_LOG2-1:0] r_cap_bin;
  sample_t              r_sk0, r_sk1, w_new;
  logic [1:0]           r_sk_cnt;

  logic                 w_pop, w_push, w_last_xfer, w_room, w_issue;
  logic                 w_in_lo, w_in_hi, w_zero, w_rd_en;
  logic                 w_have_req, w_start, w_inc;
  logic [NFFT_LOG2-1:0] w_addr_bin;

  // Output handshake and issue credit. A slot freed by this cycle's transfer
  // is already counted, which is what allows one sample per cycle.
  assign w_pop       = (r_sk_cnt != 2'd0) & bus.IFFT_Ready;
  assign w_push      = r_cap_vld;
  assign w_last_xfer = w_pop & r_sk0.last;
  assign w_room      = (({1'b0, r_cap_vld} + r_sk_cnt) - {1'b0, w_pop}) <= 2'd1;
  assign w_issue     = (r_state == S_STREAM) & w_room;

  // Bin -> subcarrier mapping: low bins carry the upper half of the grid,
  // high bins the lower half, everything in between is guard.
  assign w_in_lo    = r_bin < C_H;
  assign w_in_hi    = r_bin >= C_HI_START;
  assign w_zero     = ~(w_in_lo | w_in_hi);
  assign w_rd_en    = w_issue & ~w_zero;
  assign w_addr_bin = w_in_lo ? (r_bin + C_H) : (r_bin - C_HI_START);

  assign w_have_req = (r_pend != 2'd0) | bus.Sym_Ready;
  assign w_inc      = bus.Sym_Ready & (r_pend != 2'd2);

  // Guard bins take zero instead of whatever sits on the read bus.
  assign w_new.i    = r_cap_zero ? '0 : bus.Grid_rd_I;
  assign w_new.q    = r_cap_zero ? '0 : bus.Grid_rd_Q;
  assign w_new.bin  = r_cap_bin;
  assign w_new.last = r_cap_last;

  assign bus.Grid_rd_en   = w_rd_en;
  assign bus.Grid_rd_bank = r_bank;
  assign bus.Grid_rd_addr = w_rd_en ? ADDR_W'(w_addr_bin) : '0;
  assign bus.IFFT_Valid   = (r_sk_cnt != 2'd0);
  assign bus.IFFT_I       = r_sk0.i;
  assign bus.IFFT_Q       = r_sk0.q;
  assign bus.Bin_idx      = r_sk0.bin;
  assign bus.IFFT_Last    = r_sk0.last;
  assign bus.Buf_Free     = r_free;
  assign bus.Busy         = (r_state != S_IDLE);
  assign bus.Overflow     = r_ovf;

  // Next-state logic and symbol-start strobe.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    w_start     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_have_req) begin
          w_state_nxt = S_STREAM;
          w_start     = 1'b1;
        end
      end
      S_STREAM: begin
        if (w_issue && (r_bin == C_LAST_BIN)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_last_xfer) begin
          w_state_nxt = w_have_req ? S_STREAM : S_IDLE;
          w_start     = w_have_req;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, bin counter, pending requests, bank and status flags.
  always_ff @(posedge CLK_GF or posedge RST_GF) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (RST_GF) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_pend  <= 2'd0;
      r_ovf   <= 1'b0;
      r_bank  <= 1'b0;
      r_free  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start)      r_bin <= '0;
      else if (w_issue) r_bin <= r_bin + 1'b1;
      if (w_inc && !w_start)      r_pend <= r_pend + 2'd1;
      else if (!w_inc && w_start) r_pend <= r_pend - 2'd1;
      if (bus.Sym_Ready && (r_pend == 2'd2)) r_ovf <= 1'b1;
      r_free <= w_last_xfer;
      if (w_last_xfer) r_bank <= ~r_bank;
    end
  end

  // Capture stage: tags the read data that arrives one cycle after issue.
  always_ff @(posedge CLK_GF or posedge RST_GF) begin
    if (RST_GF) begin
      r_cap_vld  <= 1'b0;
      r_cap_zero <= 1'b0;
      r_cap_last <= 1'b0;
      r_cap_bin  <= '0;
    end else begin
      r_cap_vld  <= w_issue;
      r_cap_zero <= w_zero;
      r_cap_last <= (r_bin == C_LAST_BIN);
      r_cap_bin  <= r_bin;
    end
  end

  // Skid buffer: entry 0 drives the outputs, entry 1 absorbs one stall.
  always_ff @(posedge CLK_GF or posedge RST_GF) begin
    // NOTE: both entries are reset because entry 0 drives the outputs directly and must read zero after reset.
    if (RST_GF) begin
      r_sk_cnt <= 2'd0;
      r_sk0    <= '0;
      r_sk1    <= '0;
    end else begin
      unique case (r_sk_cnt)
        2'd0: begin
          if (w_push) begin
            r_sk0    <= w_new;
            r_sk_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_sk0 <= w_new;
          end else if (w_pop) begin
            r_sk_cnt <= 2'd0;
          end else if (w_push) begin
            r_sk1    <= w_new;
            r_sk_cnt <= 2'd2;
          end
        end
        default: begin
          // The issue credit guarantees no push arrives while full and stalled.
          if (w_pop) begin
            r_sk0 <= r_sk1;
            if (w_push) r_sk1    <= w_new;
            else        r_sk_cnt <= 2'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_grid_ifft_feeder.sv
// Directed bench for grid_ifft_feeder: a grid memory model, a transfer monitor
// with an ordered expected-sample model, and directed scenarios for latency,
// backpressure, back-to-back symbols, overflow, pending edge cases and reset.
`timescale 1ns/1ps
module tb_grid_ifft_feeder;
  localparam int DATA_W    = 18;
  localparam int NFFT_LOG2 = 11;
  localparam int N_SC      = 1200;
  localparam int ADDR_W    = 11;
  localparam int N         = 1 << NFFT_LOG2;
  localparam int H         = N_SC / 2;

  logic CLK_GF = 1'b0;
  logic RST_GF;
  logic rdy_mode;

  grid_ifft_feeder_if #(.DATA_W(DATA_W), .NFFT_LOG2(NFFT_LOG2), .ADDR_W(ADDR_W)) bus ();

  grid_ifft_feeder #(.DATA_W(DATA_W), .NFFT_LOG2(NFFT_LOG2), .N_SC(N_SC), .ADDR_W(ADDR_W)) dut (
    .CLK_GF (CLK_GF),
    .RST_GF (RST_GF),
    .bus    (bus)
  );

  always #5 CLK_GF = ~CLK_GF;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Grid contents: bank 0 holds I = addr, bank 1 holds I = addr + 4000; Q = -I.
  function automatic int mem_i(input logic b, input int a);
    return a + (b ? 4000 : 0);
  endfunction

  // Expected real part for a bin of a symbol read from bank b.
  function automatic int exp_i(input logic b, input int bin);
    if (bin < H)      return mem_i(b, bin + H);
    if (bin >= N - H) return mem_i(b, bin - (N - H));
    return 0;
  endfunction

  // Grid memory: data one cycle after the strobe, junk otherwise so that a
  // guard bin wrongly taken from the bus shows up as non-zero.
  always @(posedge CLK_GF) begin
    if (bus.Grid_rd_en) begin
      bus.Grid_rd_I <= DATA_W'(mem_i(bus.Grid_rd_bank, int'(bus.Grid_rd_addr)));
      bus.Grid_rd_Q <= DATA_W'(-mem_i(bus.Grid_rd_bank, int'(bus.Grid_rd_addr)));
    end else begin
      bus.Grid_rd_I <= DATA_W'(777);
      bus.Grid_rd_Q <= DATA_W'(-555);
    end
  end

  // IFFT ready: constant 1 or a pseudo-random 50% pattern.
  initial begin
    bus.IFFT_Ready = 1'b1;
    forever begin
      @(posedge CLK_GF);
      #1;
      bus.IFFT_Ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor state.
  int   n_xfer = 0, n_last = 0, n_free = 0, n_reads = 0;
  int   exp_bin = 0, rd_k = 0;
  logic exp_bank = 1'b0, rd_bank = 1'b0;
  logic prev_stall = 1'b0, prev_lastx = 1'b0;
  logic signed [DATA_W-1:0] pv_i, pv_q;
  logic [NFFT_LOG2-1:0]     pv_bin;
  logic                     pv_last;
  int   cap_i [N];
  int   cap_q [N];

  always @(negedge CLK_GF) begin
    if (RST_GF) begin
      exp_bin    = 0;
      exp_bank   = 1'b0;
      rd_k       = 0;
      rd_bank    = 1'b0;
      prev_stall = 1'b0;
      prev_lastx = 1'b0;
    end else begin
      if (bus.Buf_Free) n_free++;
      if (prev_lastx || bus.Buf_Free) check("buf_free_pulse", bus.Buf_Free, prev_lastx);
      if (prev_stall) begin
        check("stall_valid", bus.IFFT_Valid, 1);
        check("stall_i", bus.IFFT_I, pv_i);
        check("stall_q", bus.IFFT_Q, pv_q);
        check("stall_bin", bus.Bin_idx, pv_bin);
        check("stall_last", bus.IFFT_Last, pv_last);
      end
      if (bus.Grid_rd_en) begin
        check("rd_bank", bus.Grid_rd_bank, rd_bank);
        check("rd_addr", bus.Grid_rd_addr, (rd_k < H) ? rd_k + H : rd_k - H);
        n_reads++;
        rd_k++;
        if (rd_k == N_SC) begin
          rd_k    = 0;
          rd_bank = ~rd_bank;
        end
      end
      if (bus.IFFT_Valid && bus.IFFT_Ready) begin
        check("out_bin", bus.Bin_idx, exp_bin);
        check("out_i", bus.IFFT_I, exp_i(exp_bank, exp_bin));
        check("out_q", bus.IFFT_Q, -exp_i(exp_bank, exp_bin));
        check("out_last", bus.IFFT_Last, exp_bin == N - 1);
        cap_i[exp_bin] = int'(bus.IFFT_I);
        cap_q[exp_bin] = int'(bus.IFFT_Q);
        n_xfer++;
        if (exp_bin == N - 1) begin
          exp_bin  = 0;
          exp_bank = ~exp_bank;
          n_last++;
        end else begin
          exp_bin++;
        end
      end
      prev_lastx = bus.IFFT_Valid & bus.IFFT_Ready & bus.IFFT_Last;
      prev_stall = bus.IFFT_Valid & ~bus.IFFT_Ready;
      pv_i       = bus.IFFT_I;
      pv_q       = bus.IFFT_Q;
      pv_bin     = bus.Bin_idx;
      pv_last    = bus.IFFT_Last;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"}, bus.Grid_rd_en, 0);
    check({tag, "_rd_bank"}, bus.Grid_rd_bank, 0);
    check({tag, "_rd_addr"}, bus.Grid_rd_addr, 0);
    check({tag, "_valid"}, bus.IFFT_Valid, 0);
    check({tag, "_i"}, bus.IFFT_I, 0);
    check({tag, "_q"}, bus.IFFT_Q, 0);
    check({tag, "_last"}, bus.IFFT_Last, 0);
    check({tag, "_bin"}, bus.Bin_idx, 0);
    check({tag, "_buf_free"}, bus.Buf_Free, 0);
    check({tag, "_busy"}, bus.Busy, 0);
    check({tag, "_overflow"}, bus.Overflow, 0);
  endtask

  task automatic pulse_sym();
    @(posedge CLK_GF); #1 bus.Sym_Ready = 1'b1;
    @(posedge CLK_GF); #1 bus.Sym_Ready = 1'b0;
  endtask

  // Sym_Ready sampled at E0 from IDLE: read strobe in the next cycle, bin 0
  // valid after E0+2.
  task automatic start_sym_latency(input string tag, input int exp_i0);
    @(posedge CLK_GF); #1 bus.Sym_Ready = 1'b1;
    @(posedge CLK_GF); #1 bus.Sym_Ready = 1'b0;
    check({tag, "_lat_rd_en"}, bus.Grid_rd_en, 1);
    check({tag, "_lat_busy"}, bus.Busy, 1);
    check({tag, "_lat_valid_e1"}, bus.IFFT_Valid, 0);
    @(posedge CLK_GF); #1;
    check({tag, "_lat_valid_e2"}, bus.IFFT_Valid, 0);
    @(posedge CLK_GF); #1;
    check({tag, "_lat_valid_e3"}, bus.IFFT_Valid, 1);
    check({tag, "_lat_bin0"}, bus.Bin_idx, 0);
    check({tag, "_lat_i0"}, bus.IFFT_I, exp_i0);
  endtask

  task automatic wait_syms(input string tag, input int target, input int budget);
    int c = 0;
    while (n_last < target && c < budget) begin
      @(negedge CLK_GF);
      c++;
    end
    check({tag, "_symbols_done"}, n_last >= target, 1);
    repeat (6) @(negedge CLK_GF);
  endtask

  task automatic wait_last_xfer(input string tag, input int budget);
    int c = 0;
    @(negedge CLK_GF);
    while (!(bus.IFFT_Valid && bus.IFFT_Ready && bus.IFFT_Last) && c < budget) begin
      @(negedge CLK_GF);
      c++;
    end
    check({tag, "_last_seen"}, c < budget, 1);
  endtask

  initial begin
    int base_x, base_r, base_l, base_f, lat, c;
    RST_GF        = 1'b1;
    rdy_mode      = 1'b0;
    bus.Sym_Ready = 1'b0;
    repeat (3) @(posedge CLK_GF);
    #1 check_zero("reset");
    @(negedge CLK_GF) RST_GF = 1'b0;
    repeat (3) @(posedge CLK_GF);

    // 1: single symbol, ready held high, bank 0.
    base_x = n_xfer; base_r = n_reads;
    start_sym_latency("t1", 600);
    wait_syms("t1", 1, 3000);
    check("t1_xfers", n_xfer - base_x, N);
    check("t1_reads", n_reads - base_r, N_SC);
    check("t1_buf_free", n_free, 1);
    check("t1_bank", bus.Grid_rd_bank, 1);
    check("t1_busy", bus.Busy, 0);
    check("t1_bin0_i", cap_i[0], 600);
    check("t1_bin0_q", cap_q[0], -600);
    check("t1_bin599_i", cap_i[599], 1199);
    check("t1_bin599_q", cap_q[599], -1199);
    check("t1_bin600_i", cap_i[600], 0);
    check("t1_bin1447_q", cap_q[1447], 0);
    check("t1_bin1448_i", cap_i[1448], 0);
    check("t1_bin1448_q", cap_q[1448], 0);
    check("t1_bin2047_i", cap_i[2047], 599);
    check("t1_bin2047_q", cap_q[2047], -599);

    // 2: random backpressure, bank 1.
    rdy_mode = 1'b1;
    base_x = n_xfer;
    start_sym_latency("t2", 4600);
    wait_syms("t2", 2, 12000);
    rdy_mode = 1'b0;
    check("t2_xfers", n_xfer - base_x, N);
    check("t2_buf_free", n_free, 2);
    check("t2_bank", bus.Grid_rd_bank, 0);
    check("t2_bin0_i", cap_i[0], 4600);
    check("t2_bin2047_q", cap_q[2047], -4599);
    check("t2_bin1000_i", cap_i[1000], 0);

    // 3: two requests 10 cycles apart; second symbol reads bank 1.
    pulse_sym();
    repeat (10) @(posedge CLK_GF);
    pulse_sym();
    wait_last_xfer("t3", 3000);
    lat = 0;
    c   = 0;
    @(negedge CLK_GF);
    lat = 1;
    while (!bus.IFFT_Valid && c < 10) begin
      @(negedge CLK_GF);
      lat++;
      c++;
    end
    check("t3_b2b_latency_ok", lat <= 3, 1);
    check("t3_b2b_bin0", bus.Bin_idx, 0);
    check("t3_b2b_i0", bus.IFFT_I, 4600);
    wait_syms("t3", 4, 3000);
    check("t3_buf_free", n_free, 4);
    check("t3_bank", bus.Grid_rd_bank, 0);
    check("t3_busy", bus.Busy, 0);

    // 4: three extra requests during a symbol -> overflow, 3 symbols total.
    base_l = n_last;
    pulse_sym();
    repeat (50) @(posedge CLK_GF);
    pulse_sym();
    repeat (5) @(posedge CLK_GF);
    pulse_sym();
    check("t4_ovf_after_2", bus.Overflow, 0);
    repeat (5) @(posedge CLK_GF);
    pulse_sym();
    check("t4_ovf_after_3", bus.Overflow, 1);
    wait_syms("t4", base_l + 3, 8000);
    repeat (20) @(negedge CLK_GF);
    check("t4_symbols", n_last - base_l, 3);
    check("t4_busy", bus.Busy, 0);
    check("t4_ovf_sticky", bus.Overflow, 1);
    check("t4_bank", bus.Grid_rd_bank, 1);

    // 6: request coinciding with the last transfer is served next.
    base_l = n_last;
    pulse_sym();
    wait_last_xfer("t6", 3000);
    bus.Sym_Ready = 1'b1;
    @(posedge CLK_GF); #1 bus.Sym_Ready = 1'b0;
    check("t6_restream_busy", bus.Busy, 1);
    wait_syms("t6", base_l + 2, 6000);
    repeat (20) @(negedge CLK_GF);
    check("t6_symbols", n_last - base_l, 2);
    check("t6_busy", bus.Busy, 0);
    check("t6_bank", bus.Grid_rd_bank, 1);

    // 5: reset at bin 1000 aborts; restart from bank 0 bin 0.
    base_f = n_free;
    base_l = n_last;
    pulse_sym();
    c = 0;
    @(negedge CLK_GF);
    while (!(bus.IFFT_Valid && bus.Bin_idx == 11'd1000) && c < 3000) begin
      @(negedge CLK_GF);
      c++;
    end
    check("t5_bin1000_seen", c < 3000, 1);
    RST_GF = 1'b1;
    #1 check_zero("t5_rst");
    repeat (3) @(posedge CLK_GF);
    @(negedge CLK_GF) RST_GF = 1'b0;
    repeat (3) @(negedge CLK_GF);
    check("t5_no_buf_free", n_free, base_f);
    check("t5_no_last", n_last, base_l);
    check("t5_bank_after_rst", bus.Grid_rd_bank, 0);
    start_sym_latency("t5", 600);
    wait_syms("t5", base_l + 1, 3000);
    check("t5_buf_free", n_free, base_f + 1);
    check("t5_bank", bus.Grid_rd_bank, 1);
    check("t5_bin2047_i", cap_i[2047], 599);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
    $fatal(1, "watchdog");
  end
endmodule
